uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_ctrl_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/uart_tx_scheduler.sv | 157 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the FSM state encoding, the baud-rate selection codes and a counter sizing helper.
// No logic lives here.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam logic [1:0] BAUD_OFF    = 2'b00;
  localparam logic [1:0] BAUD_9600   = 2'b01;
  localparam logic [1:0] BAUD_57600  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  // Bit counter width; a one-bit payload still needs a one-bit counter.
  function automatic int cnt_width(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: picks between requester 0 (A) and 1 (B).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
// Ports: valid[1:0] requests, last_grant (0=A, 1=B) owner of the previous grant,
//        grant winner index, win_vld high when any request is present.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       win_vld
);

  always_comb begin
    win_vld = |valid;
    // A lone requester always wins; on contention the previous owner yields.
    grant = valid[1];
    if (&valid) begin
      grant = ~last_grant;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmitter shared by two requesters with round-robin arbitration and baud-code capture.
// Latency: ready one cycle after acceptance; frame is 0-1 bit periods of alignment plus DATA_BITS+2 bit periods.
// Backpressure: a requester holds valid until its one-cycle ready pulse; nothing is accepted while a frame is in flight.
// Ports: clock/reset (sync, active high); cfg_baud_sel in, baudrate_sel out (held outside IDLE);
//        baud_tick bit-period strobe; a_/b_ valid, data, ready; tx serial line; busy, grant_b, frame_done status.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           cfg_baud_sel,
  output logic [1:0]           baudrate_sel,
  input  logic                 baud_tick,
  input  logic                 a_valid,
  input  logic [DATA_BITS-1:0] a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [DATA_BITS-1:0] b_data,
  output logic                 b_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 grant_b,
  output logic                 frame_done
);

  localparam int             CNT_W    = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  state_e                 state_q, state_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   a_ready_q, a_ready_d;
  logic                   b_ready_q, b_ready_d;
  logic                   frame_done_q, frame_done_d;
  logic                   grant_b_q, grant_b_d;
  logic [1:0]             baud_q, baud_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;

  logic                   arb_grant;
  logic                   arb_vld;

  rr_arbiter2 u_arb (
    .valid      ({b_valid, a_valid}),
    .last_grant (grant_b_q),
    .grant      (arb_grant),
    .win_vld    (arb_vld)
  );

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    a_ready_d    = 1'b0;
    b_ready_d    = 1'b0;
    frame_done_d = 1'b0;
    grant_b_d    = grant_b_q;
    baud_d       = baud_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;

    case (state_q)
      ST_IDLE: begin
        baud_d = cfg_baud_sel;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // baud_tick is deliberately ignored here: ALIGN waits for the next
        // tick so the start bit always spans one full interval.
        if (baud_q != BAUD_OFF && arb_vld) begin
          a_ready_d = ~arb_grant;
          b_ready_d = arb_grant;
          grant_b_d = arb_grant;
          shift_d   = arb_grant ? b_data : a_data;
          busy_d    = 1'b1;
          state_d   = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (cnt_q == CNT_LAST) begin
            // Clear rather than increment so the counter never wraps.
            cnt_d   = '0;
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            tx_d  = shift_d[0];
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          tx_d         = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      a_ready_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      frame_done_q <= 1'b0;
      grant_b_q    <= 1'b1;  // A wins the first contention after reset
      baud_q       <= BAUD_OFF;
      cnt_q        <= '0;
      shift_q      <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      a_ready_q    <= a_ready_d;
      b_ready_q    <= b_ready_d;
      frame_done_q <= frame_done_d;
      grant_b_q    <= grant_b_d;
      baud_q       <= baud_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
    end
  end

  assign tx           = tx_q;
  assign busy         = busy_q;
  assign a_ready      = a_ready_q;
  assign b_ready      = b_ready_q;
  assign frame_done   = frame_done_q;
  assign grant_b      = grant_b_q;
  assign baudrate_sel = baud_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized frames.
// A serial-line monitor reconstructs each frame and compares it with expectations queued by the stimulus.
// The stimulus side keeps a round-robin owner model and the expected payload per frame.
module tb_uart_tx_scheduler;

  typedef struct {
    bit         owner;  // 0=A, 1=B
    logic [7:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cfg_baud_sel = 2'b00;
  logic [1:0] baudrate_sel;
  logic       baud_tick = 1'b0;
  logic       a_valid = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_ready;
  logic       b_valid = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_ready;
  logic       tx;
  logic       busy;
  logic       grant_b;
  logic       frame_done;

  int   n_total = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   acc_idx = 0;        // entries at the head of exp_q already accepted by the DUT
  int   cyc = 0;
  int   tick_per = 16;
  int   tick_cnt = 0;
  bit   mon_active = 1'b0;
  int   mon_start = 0;
  int   last_ready_cyc = 0;
  int   last_done_cyc = -1;
  int   done_cnt = 0;
  bit   expect_b2b = 1'b0;
  bit   model_last_b = 1'b1;

  uart_tx_scheduler #(.DATA_BITS(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_baud_sel (cfg_baud_sel),
    .baudrate_sel (baudrate_sel),
    .baud_tick    (baud_tick),
    .a_valid      (a_valid),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .tx           (tx),
    .busy         (busy),
    .grant_b      (grant_b),
    .frame_done   (frame_done)
  );

  initial forever #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Baud strobe: one pulse every tick_per cycles.
  initial forever begin
    @(posedge clock);
    #1;
    if (tick_cnt >= tick_per - 1) begin
      tick_cnt  = 0;
      baud_tick = 1'b1;
    end else begin
      tick_cnt++;
      baud_tick = 1'b0;
    end
  end

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: time limit reached, got no end of test, required completion");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Reference model: a lone requester wins, contention goes to the other side of the last owner.
  task automatic push_expect(input bit va, input bit vb, input logic [7:0] da, input logic [7:0] db);
    exp_t e;
    bit   w;
    w = (va && vb) ? !model_last_b : vb;
    model_last_b = w;
    e.owner = w;
    e.data  = w ? db : da;
    exp_q.push_back(e);
  endtask

  task automatic send(input bit va, input bit vb, input logic [7:0] da, input logic [7:0] db,
                      input bit sync_tick);
    int t;
    push_expect(va, vb, da, db);
    if (sync_tick) begin
      t = 0;
      while (baud_tick !== 1'b1 && t < 100) begin
        step();
        t++;
      end
    end
    a_data  = da;
    b_data  = db;
    a_valid = va;
    b_valid = vb;
    t = 0;
    do begin
      step();
      t++;
    end while (!(a_ready || b_ready) && t < 400);
    check("accept_in_time", 32'(a_ready || b_ready), 1);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 3000) begin
      step();
      t++;
    end
    check("frame_done_seen", 32'(done_cnt >= target), 1);
  endtask

  task automatic wait_mid_frame(input int offset);
    int t;
    t = 0;
    while (!(mon_active && cyc >= mon_start + offset) && t < 3000) begin
      step();
      t++;
    end
    check("reached_frame_point", 32'(mon_active), 1);
  endtask

  // Monitor: reconstructs frames from tx and checks ready/frame_done against the queue.
  initial begin : monitor
    int         off;
    int         k;
    logic [9:0] first_bits;
    logic [9:0] last_bits;
    logic [9:0] exp_frame;
    logic [1:0] exp_rdy;
    exp_t       e;
    first_bits = '1;
    last_bits  = '1;
    forever begin
      @(negedge clock);
      if (reset) begin
        // An accepted but unfinished frame is discarded by reset.
        if (acc_idx > 0) begin
          exp_q.delete(0);
          acc_idx = 0;
        end
        mon_active    = 1'b0;
        last_done_cyc = -1;
      end else begin
        if (a_ready || b_ready) begin
          exp_rdy = 2'b00;
          if (acc_idx < exp_q.size()) begin
            exp_rdy = exp_q[acc_idx].owner ? 2'b10 : 2'b01;
            acc_idx++;
          end
          check("ready_owner", 32'({b_ready, a_ready}), 32'(exp_rdy));
          last_ready_cyc = cyc;
          if (expect_b2b && last_done_cyc >= 0) begin
            check("back_to_back_gap", cyc - last_done_cyc, 1);
          end
        end
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1'b1;
          mon_start  = cyc;
          first_bits = '1;
          last_bits  = '1;
          check("align_latency_in_range",
                32'((cyc - last_ready_cyc >= 1) && (cyc - last_ready_cyc <= tick_per)), 1);
        end
        if (mon_active) begin
          off = cyc - mon_start;
          if (off < 10 * tick_per) begin
            k = off / tick_per;
            if (off % tick_per == 0) first_bits[k] = tx;
            if (off % tick_per == tick_per - 1) last_bits[k] = tx;
          end
        end
        if (frame_done) begin
          check("done_matches_pending_frame",
                32'(exp_q.size() != 0 && acc_idx > 0 && mon_active), 1);
          if (exp_q.size() != 0 && acc_idx > 0 && mon_active) begin
            e = exp_q.pop_front();
            acc_idx--;
            exp_frame = {1'b1, e.data, 1'b0};
            check("frame_length", cyc - mon_start, 10 * tick_per);
            check("frame_bits_first_cycle", 32'(first_bits), 32'(exp_frame));
            check("frame_bits_last_cycle", 32'(last_bits), 32'(exp_frame));
            check("frame_owner", 32'(grant_b), 32'(e.owner));
          end
          mon_active    = 1'b0;
          last_done_cyc = cyc;
          done_cnt++;
        end
      end
    end
  end

  initial begin : stim
    int         t;
    int         rdy_cyc;
    int         nrdy;
    int         base;
    logic [7:0] da;
    logic [7:0] db;
    logic [1:0] patt;
    logic [1:0] cfg;

    repeat (3) step();
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'({a_ready, b_ready}), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_grant_b", 32'(grant_b), 1);
    check("rst_baudrate_sel", 32'(baudrate_sel), 0);
    reset = 1'b0;

    // Single A frame with payload A5 at 16 cycles per bit.
    cfg_baud_sel = 2'b01;
    tick_per     = 16;
    step();
    send(1'b1, 1'b0, 8'hA5, 8'h00, 1'b0);
    wait_done(1);

    // Acceptance coincident with a tick: start bit begins one full interval later.
    send(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b1);
    rdy_cyc = cyc;
    wait_mid_frame(0);
    check("start_after_tick_accept", mon_start - rdy_cyc, tick_per);
    wait_done(2);

    // From reset, both held: A,B,A,B back-to-back.
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_last_b = 1'b1;
    expect_b2b   = 1'b1;
    base = done_cnt;
    for (int i = 0; i < 4; i++) push_expect(1'b1, 1'b1, 8'h11, 8'h22);
    a_data = 8'h11;
    b_data = 8'h22;
    a_valid = 1'b1;
    b_valid = 1'b1;
    nrdy = 0;
    t = 0;
    while (nrdy < 4 && t < 4000) begin
      step();
      t++;
      if (a_ready || b_ready) nrdy++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("four_acceptances", nrdy, 4);
    wait_done(base + 4);
    expect_b2b = 1'b0;

    // Disabled rate: a dropped request is forgotten, a held one waits.
    cfg_baud_sel = 2'b00;
    step();
    b_valid = 1'b1;
    b_data  = 8'($urandom);
    repeat (5) step();
    b_valid = 1'b0;
    cfg_baud_sel = 2'b01;
    for (int i = 0; i < 30; i++) begin
      step();
      check("dropped_valid_no_grant", 32'({a_ready, b_ready, busy}), 0);
    end
    cfg_baud_sel = 2'b00;
    step();
    da = 8'($urandom);
    push_expect(1'b1, 1'b0, da, 8'h00);
    a_data  = da;
    a_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check("cfg_off_stays_idle", 32'({a_ready, busy, tx}), 1);
    end
    cfg_baud_sel = 2'b11;
    t = 0;
    do begin
      step();
      t++;
    end while (!a_ready && t < 20);
    a_valid = 1'b0;
    check("accept_after_enable_latency", t, 2);
    check("baud_after_enable", 32'(baudrate_sel), 3);
    wait_done(base + 5);

    // Rate change mid-frame is held until IDLE.
    cfg_baud_sel = 2'b01;
    step();
    send(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b0);
    wait_mid_frame(2 * tick_per + 3);
    cfg_baud_sel = 2'b11;
    t = 0;
    while (done_cnt < base + 6 && t < 3000) begin
      check("baud_held_in_frame", 32'(baudrate_sel), 1);
      step();
      t++;
    end
    check("frame_done_seen", 32'(done_cnt >= base + 6), 1);
    check("baud_after_frame", 32'(baudrate_sel), 3);

    // Reset on the 4th data bit aborts the frame; A then wins contention.
    cfg_baud_sel = 2'b01;
    step();
    send(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b0);
    wait_mid_frame(4 * tick_per + tick_per / 2);
    reset = 1'b1;
    step();
    check("abort_tx", 32'(tx), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_baud", 32'(baudrate_sel), 0);
    check("abort_no_done", 32'(frame_done), 0);
    reset = 1'b0;
    model_last_b = 1'b1;
    base = done_cnt;
    send(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
    wait_done(base + 1);

    // Randomized frames with varying bit periods, patterns and rate codes.
    for (int i = 0; i < 12; i++) begin
      tick_per     = int'($urandom_range(2, 12));
      cfg          = 2'($urandom_range(1, 3));
      cfg_baud_sel = cfg;
      step();
      patt = 2'($urandom_range(1, 3));
      da   = 8'($urandom);
      db   = 8'($urandom);
      send(patt[0], patt[1], da, db, 1'($urandom_range(0, 1)));
      check("baud_code_latched", 32'(baudrate_sel), 32'(cfg));
      wait_done(base + 2 + i);
      repeat ($urandom_range(0, 4)) step();
    end

    repeat (5) step();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
